// File: rtl/alu_instr_sequencer.sv
// Hardwired T0..T6 fetch/execute sequencer for the bus-based datapath.
// It drives the datapath strobes for ALU, MUL/DIV and HALT instructions, and adds a memory-ready timeout and a retired-instruction counter.
module alu_instr_sequencer #(
  parameter logic [4:0] MUL_OP      = 5'b01110,
  parameter logic [4:0] DIV_OP      = 5'b01111,
  parameter logic [4:0] HALT_OP     = 5'b11011,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Run,
  input  logic        Mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  opcode,
  output logic        Busy,
  output logic        Halted,
  output logic        Err,
  output logic [15:0] Instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;
  logic        retire_s;

  logic [4:0] op_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       is_muldiv_s, is_halt_s;
  logic       unused_ir_bits;

  assign op_s        = IR[31:27];
  assign ra_s        = IR[26:23];
  assign rb_s        = IR[22:19];
  assign rc_s        = IR[18:15];
  assign is_muldiv_s = (op_s == MUL_OP) || (op_s == DIV_OP);
  assign is_halt_s   = (op_s == HALT_OP);
  assign unused_ir_bits = ^IR[14:0];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    count_d  = count_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_T0;
        else     state_d = S_IDLE;
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = 4'd0;
      end
      S_T1: begin
        if (Mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          wait_d  = 4'd0;
          state_d = S_IDLE;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_halt_s) begin
          state_d = S_HALT;
          count_d = count_q + 16'd1;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_muldiv_s) state_d = S_T6;
        else             retire_s = 1'b1;
      end
      S_T6:   retire_s = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Run is only looked at here and in IDLE, so it may drop mid-instruction.
    if (retire_s) begin
      count_d = count_q + 16'd1;
      state_d = Run ? S_T0 : S_IDLE;
    end else begin
      count_d = count_d;
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      err_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Strobes decode the registered state; IR fields are only trusted from T3 on.
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; PCin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    LOin = 1'b0; HIin = 1'b0;
    Rin = 16'd0; Rout = 16'd0; opcode = 5'd0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (!is_halt_s) begin
          Rout = 16'd1 << rb_s;
          Yin  = 1'b1;
        end else begin
          Yin  = 1'b0;
        end
      end
      S_T4: begin
        Rout   = 16'd1 << rc_s;
        Zin    = 1'b1;
        opcode = op_s;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv_s) LOin = 1'b1;
        else             Rin  = 16'd1 << ra_s;
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: opcode = 5'd0;
    endcase
  end

  assign Busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign Halted      = (state_q == S_HALT);
  assign Err         = err_q;
  assign Instr_count = count_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: a small bus datapath model around the sequencer,
// with per-cycle expected output vectors queued per instruction and compared as the DUT steps.
module tb_alu_instr_sequencer;

  logic        Clock, clear, Run, Mem_ready;
  logic [31:0] ir_q;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, LOin, HIin;
  logic [15:0] Rin, Rout, Instr_count;
  logic [4:0]  opcode;
  logic        Busy, Halted, Err;

  alu_instr_sequencer dut (
    .Clock(Clock), .clear(clear), .Run(Run), .Mem_ready(Mem_ready), .IR(ir_q),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .Busy(Busy), .Halted(Halted), .Err(Err), .Instr_count(Instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Datapath model
  logic [31:0] regs [16];
  logic [31:0] pc_q, mdr_q, y_q, lo_q, hi_q, bus_s, mem_word;
  logic [63:0] z_q;
  logic        dp_init;
  int          drivers_s;
  int          conflicts = 0;

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00011: alu = {32'd0, a + b};
      5'b01110: alu = {32'd0, a} * {32'd0, b};
      5'b01111: alu = (b == 32'd0) ? 64'd0 : {a % b, a / b};
      default:  alu = 64'd0;
    endcase
  endfunction

  always_comb begin
    bus_s = 32'd0;
    drivers_s = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + $countones(Rout);
    if (PCout)    bus_s = pc_q;
    if (Zlowout)  bus_s = z_q[31:0];
    if (Zhighout) bus_s = z_q[63:32];
    if (MDRout)   bus_s = mdr_q;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus_s = regs[i];
  end

  always @(posedge Clock) begin
    if (dp_init) begin
      pc_q <= 32'd0; lo_q <= 32'd0; hi_q <= 32'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      regs[2] <= 32'd8;
      regs[3] <= 32'd9;
    end else begin
      if (Read && MDRin && Mem_ready) mdr_q <= mem_word;
      if (PCin) pc_q <= bus_s;
      if (IRin) ir_q <= bus_s;
      if (Yin)  y_q  <= bus_s;
      if (LOin) lo_q <= bus_s;
      if (HIin) hi_q <= bus_s;
      if (Zin)  z_q  <= IncPC ? {32'd0, bus_s + 32'd1} : alu(opcode, y_q, bus_s);
      for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus_s;
    end
    if (drivers_s > 1) conflicts <= conflicts + 1;
  end

  // Expected vectors: {strobes[13:0], Rin, Rout, opcode, Busy, Halted}
  localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800,
    S_ZIN = 14'h0400, S_ZLO = 14'h0200, S_ZHI = 14'h0100, S_PCIN = 14'h0080,
    S_READ = 14'h0040, S_MDRIN = 14'h0020, S_MDROUT = 14'h0010, S_IRIN = 14'h0008,
    S_YIN = 14'h0004, S_LOIN = 14'h0002, S_HIIN = 14'h0001;

  function automatic logic [52:0] v(input logic [13:0] s, input logic [15:0] rin,
                                    input logic [15:0] rout, input logic [4:0] op,
                                    input logic busy, input logic halted);
    v = {s, rin, rout, op, busy, halted};
  endfunction

  function automatic logic [52:0] observed();
    observed = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
                MDRout, IRin, Yin, LOin, HIin, Rin, Rout, opcode, Busy, Halted};
  endfunction

  localparam logic [31:0] W_ADD = 32'h18918000, W_MUL = 32'h70918000, W_HALT = 32'hD8000000;

  logic [52:0] V_IDLE, V_T0, V_T1, V_T2, V_T3, V_T4A, V_T5A, V_T4M, V_T5M, V_T6M, V_HALT;
  logic [52:0] exp_q [$];
  int checks = 0, failures = 0;
  int rd_delay = 0, rd_cycles = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the negedge, then play memory against Read.
  task automatic step();
    @(negedge Clock);
    if (Read) begin
      Mem_ready = (rd_cycles >= rd_delay);
      rd_cycles++;
    end else begin
      Mem_ready = 1'b0;
      rd_cycles = 0;
    end
  endtask

  task automatic start_instr(input logic [31:0] word, input int delay);
    mem_word = word;
    rd_delay = delay;
    Run = 1'b1;
  endtask

  task automatic drain(input string tag);
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      step();
      check_eq(tag, 64'(observed()), 64'(exp_q.pop_front()));
      if (first) Run = 1'b0;
      first = 1'b0;
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back(V_T0);
    exp_q.push_back(V_T1);
    exp_q.push_back(V_T2);
  endtask

  task automatic push_add();
    push_fetch();
    exp_q.push_back(V_T3);
    exp_q.push_back(V_T4A);
    exp_q.push_back(V_T5A);
  endtask

  task automatic dp_reload();
    dp_init = 1'b1;
    step();
    dp_init = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    V_IDLE = 53'd0;
    V_T0   = v(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0);
    V_T1   = v(S_ZLO | S_PCIN | S_READ | S_MDRIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0);
    V_T2   = v(S_MDROUT | S_IRIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0);
    V_T3   = v(S_YIN, 16'd0, 16'h0004, 5'd0, 1'b1, 1'b0);
    V_T4A  = v(S_ZIN, 16'd0, 16'h0008, 5'b00011, 1'b1, 1'b0);
    V_T5A  = v(S_ZLO, 16'h0002, 16'd0, 5'd0, 1'b1, 1'b0);
    V_T4M  = v(S_ZIN, 16'd0, 16'h0008, 5'b01110, 1'b1, 1'b0);
    V_T5M  = v(S_ZLO | S_LOIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0);
    V_T6M  = v(S_ZHI | S_HIIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0);
    V_HALT = v(14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);

    clear = 1'b1; Run = 1'b0; Mem_ready = 1'b0; dp_init = 1'b1; mem_word = 32'd0;
    repeat (2) step();
    check_eq("reset_outputs", 64'(observed()), 64'(V_IDLE));
    check_eq("reset_count", 64'(Instr_count), 64'd0);
    check_eq("reset_err", 64'(Err), 64'd0);
    clear = 1'b0;
    dp_init = 1'b0;
    step();
    check_eq("idle_no_run", 64'(observed()), 64'(V_IDLE));

    // add R1,R2,R3 with memory ready immediately
    start_instr(W_ADD, 0);
    push_add();
    drain("add_seq");
    step();
    check_eq("add_r1", 64'(regs[1]), 64'd17);
    check_eq("add_count", 64'(Instr_count), 64'd1);
    check_eq("add_idle", 64'(observed()), 64'(V_IDLE));

    // same add with three wait cycles in T1
    dp_reload();
    start_instr(W_ADD, 3);
    exp_q.push_back(V_T0);
    repeat (4) exp_q.push_back(V_T1);
    exp_q.push_back(V_T2);
    exp_q.push_back(V_T3);
    exp_q.push_back(V_T4A);
    exp_q.push_back(V_T5A);
    drain("wait_seq");
    step();
    check_eq("wait_r1", 64'(regs[1]), 64'd17);
    check_eq("wait_count", 64'(Instr_count), 64'd2);

    // memory never ready: 15 cycles of T1, then Err and IDLE
    start_instr(W_ADD, 1000000);
    exp_q.push_back(V_T0);
    repeat (15) exp_q.push_back(V_T1);
    exp_q.push_back(V_IDLE);
    drain("timeout_seq");
    check_eq("timeout_err", 64'(Err), 64'd1);
    check_eq("timeout_busy", 64'(Busy), 64'd0);
    check_eq("timeout_count", 64'(Instr_count), 64'd2);
    start_instr(W_ADD, 0);
    push_add();
    drain("refetch_seq");
    step();
    check_eq("err_sticky", 64'(Err), 64'd1);
    check_eq("refetch_count", 64'(Instr_count), 64'd3);

    // multiply: LO then HI write-back
    dp_reload();
    start_instr(W_MUL, 0);
    push_fetch();
    exp_q.push_back(V_T3);
    exp_q.push_back(V_T4M);
    exp_q.push_back(V_T5M);
    exp_q.push_back(V_T6M);
    drain("mul_seq");
    step();
    check_eq("mul_lo", 64'(lo_q), 64'd72);
    check_eq("mul_hi", 64'(hi_q), 64'd0);
    check_eq("mul_count", 64'(Instr_count), 64'd4);
    check_eq("mul_idle", 64'(observed()), 64'(V_IDLE));

    // clear in the middle of T4
    start_instr(W_ADD, 0);
    push_fetch();
    exp_q.push_back(V_T3);
    exp_q.push_back(V_T4A);
    drain("pre_clear_seq");
    clear = 1'b1;
    #1;
    check_eq("clear_outputs", 64'(observed()), 64'(V_IDLE));
    check_eq("clear_count", 64'(Instr_count), 64'd0);
    check_eq("clear_err", 64'(Err), 64'd0);
    step();
    clear = 1'b0;
    step();
    check_eq("post_clear_idle", 64'(observed()), 64'(V_IDLE));

    // halt: absorbing until clear
    start_instr(W_HALT, 0);
    push_fetch();
    exp_q.push_back(v(14'd0, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(V_HALT);
    drain("halt_seq");
    check_eq("halt_count", 64'(Instr_count), 64'd1);
    for (int i = 0; i < 4; i++) begin
      Run = ~Run;
      step();
      check_eq("halt_hold", 64'(observed()), 64'(V_HALT));
    end
    Run = 1'b0;
    clear = 1'b1;
    #1;
    check_eq("halt_clear", 64'(observed()), 64'(V_IDLE));
    check_eq("halt_clear_count", 64'(Instr_count), 64'd0);
    step();
    clear = 1'b0;
    step();
    check_eq("halt_exit_idle", 64'(observed()), 64'(V_IDLE));

    check_eq("bus_exclusive", 64'(conflicts), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Hardwired control sequencer for the bus-based datapath. It drives the same strobes a bench would otherwise hand-drive: PCout/MARin/IncPC/Zin fetch, IR load, Y/Z ALU staging and register write-back. It runs the T0..T6 fetch/execute sequence for register-register ALU, multiply and divide instructions, with a memory-ready wait, a fetch timeout, a halt opcode and an instruction counter.

Parameters:
MUL_OP, 5'b01110, opcode whose 64-bit result writes LO (from Zlow) then HI (from Zhigh)
DIV_OP, 5'b01111, same two-step write-back as MUL_OP
HALT_OP, 5'b11011, opcode that stops sequencing
MEM_TIMEOUT, 15, maximum cycles spent in T1 waiting for Mem_ready

Ports:
Clock  in  1  single system clock, all state updates on posedge
clear  in  1  asynchronous, active-high reset
Run  in  1  level; start from IDLE, continue at instruction boundary
Mem_ready  in  1  memory data valid on Mdatain this cycle
IR  in  32  datapath IR contents; [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath strobes
Rin  out  16  one-hot register load enables, bit n = Rn_in
Rout  out  16  one-hot register drive enables, bit n = Rn_out
opcode  out  5  ALU operation select
Busy  out  1  high in any state except IDLE/HALT
Halted  out  1  high in HALT
Err  out  1  sticky fetch-timeout flag
Instr_count  out  16  count of retired instructions

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State register updates on posedge Clock. Outputs are a Moore decode of state (plus IR/op fields) and hold for the whole state cycle. The datapath captures them at the posedge ending that state.
- clear=1 (any time, including mid-instruction): immediately go to IDLE. All strobes 0, Rin/Rout 0, opcode 0, Err 0, Instr_count 0, timeout counter 0.
- IDLE: all strobes 0. Go to T0 when Run=1.
- T0: PCout, MARin, IncPC, Zin. Next state T1; wait counter cleared.
- T1: Zlowout, PCin, Read, MDRin. If Mem_ready=1, go to T2.
  - Otherwise stay in T1 and increment the wait counter. Repeated PCin is harmless because Z is unchanged.
  - If the counter reaches MEM_TIMEOUT with Mem_ready still 0: set Err and go to IDLE.
- T2: MDRout, IRin. Next state T3.
- T3: decode. If IR[31:27]==HALT_OP: go to HALT with no strobes and increment Instr_count. Otherwise Rout[IR[22:19]], Yin, and go to T4.
- T4: Rout[IR[18:15]], Zin, opcode=IR[31:27]. opcode is 0 in every other state. Next state T5.
- T5:
  - MUL_OP/DIV_OP: Zlowout, LOin; next state T6.
  - Other ops: Zlowout, Rin[IR[26:23]]; retire.
- T6: Zhighout, HIin; retire.
- Retire: Instr_count increments by 1 and wraps 16'hFFFF->0. Next state is T0 if Run=1, else IDLE. Run is sampled only at retire and in IDLE.
- HALT: absorbing state; only clear leaves it. Halted=1, Busy=0.
- Rin/Rout are exactly one-hot when active and all-zero otherwise. Ra=Rb=Rc is legal (e.g. add R0,R0,R0).
- Err is sticky and is cleared only by clear. Run=1 after a timeout restarts fetch at T0.
- At most one bus driver (PCout, Zlowout, Zhighout, MDRout, any Rout) is active in any cycle.

Test Plan:
- Preload R2=8, R3=9, PC=0. Memory returns 0x18918000 with Mem_ready=1 in T1 -> states T0..T5 in 6 cycles. T4 shows Rout=0x0008 and opcode=5'b00011. T5 shows Rin=0x0002. R1 becomes 17 and Instr_count=1.
- Mem_ready held low 3 cycles in T1 -> T1 lasts 4 cycles and PCin stays high throughout. The add retires 3 cycles later than the no-wait case, with the same result.
- Mem_ready never asserted -> after 15 cycles in T1, Err=1, state IDLE, Busy=0. Err stays 1 across a subsequent Run=1 fetch.
- IR=0x70918000 (MUL_OP, Rb=R2=8, Rc=R3=9) -> T5 shows LOin+Zlowout, T6 shows HIin+Zhighout. LO=72, HI=0, retire after 7 cycles.
- IR=0xD8000000 (HALT_OP) -> HALT after T3, Halted=1, Instr_count incremented. Run toggling has no effect; clear returns to IDLE.
- clear pulsed during T4 -> all outputs 0 within the same cycle, and Instr_count=0.
